// File: rtl/my_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
//   - alu_op_t     : ALU operation codes driven on alu_sel_o (SEL_WIDTH bits)
//   - ctrl_state_t : 4-bit FSM state encoding, visible on state_o
//   - alu_class_t  : instruction class handed to the ALU decoder
//   - opcode/funct field values and the datapath mux select codes
package my_pkg;

    localparam int unsigned OP_WIDTH  = 6;
    localparam int unsigned SEL_WIDTH = 4;

    typedef enum logic [SEL_WIDTH-1:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnnd = 4'd2,
        AluOor  = 4'd3,
        AluNoor = 4'd4,
        AluSlt  = 4'd5,
        AluSll  = 4'd6,
        AluSrl  = 4'd7
    } alu_op_t;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StAluWbR = 4'd7,
        StExecI  = 4'd8,
        StAluWbI = 4'd9,
        StBranch = 4'd10,
        StJump   = 4'd11
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ClsAdd    = 2'd0,
        ClsR      = 2'd1,
        ClsI      = 2'd2,
        ClsBranch = 2'd3
    } alu_class_t;

    // Opcode field values
    localparam logic [OP_WIDTH-1:0] OpRtype = 6'b000000;
    localparam logic [OP_WIDTH-1:0] OpJ     = 6'b000010;
    localparam logic [OP_WIDTH-1:0] OpBeq   = 6'b000100;
    localparam logic [OP_WIDTH-1:0] OpBne   = 6'b000101;
    localparam logic [OP_WIDTH-1:0] OpAddi  = 6'b001000;
    localparam logic [OP_WIDTH-1:0] OpAndi  = 6'b001100;
    localparam logic [OP_WIDTH-1:0] OpOri   = 6'b001101;
    localparam logic [OP_WIDTH-1:0] OpLw    = 6'b100011;
    localparam logic [OP_WIDTH-1:0] OpSw    = 6'b101011;

    // Funct field values
    localparam logic [OP_WIDTH-1:0] FnSll = 6'b000000;
    localparam logic [OP_WIDTH-1:0] FnSrl = 6'b000010;
    localparam logic [OP_WIDTH-1:0] FnAdd = 6'b100000;
    localparam logic [OP_WIDTH-1:0] FnSub = 6'b100010;
    localparam logic [OP_WIDTH-1:0] FnAnd = 6'b100100;
    localparam logic [OP_WIDTH-1:0] FnOr  = 6'b100101;
    localparam logic [OP_WIDTH-1:0] FnNor = 6'b100111;
    localparam logic [OP_WIDTH-1:0] FnSlt = 6'b101010;

    // ALU A source
    localparam logic [1:0] SrcAPc = 2'b00;
    localparam logic [1:0] SrcARs = 2'b01;
    localparam logic [1:0] SrcARt = 2'b10;

    // ALU B source
    localparam logic [2:0] SrcBRt     = 3'b000;
    localparam logic [2:0] SrcBFour   = 3'b001;
    localparam logic [2:0] SrcBSImm   = 3'b010;
    localparam logic [2:0] SrcBSImmSh = 3'b011;
    localparam logic [2:0] SrcBZImm   = 3'b100;
    localparam logic [2:0] SrcBShamt  = 3'b101;

    // PC source
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mips_multi_ctrl_if.sv
// Control bundle between the multicycle control FSM and the datapath.
//   Inputs to the controller : opcode_i, funct_i, zeroflag_i (+ mem_ready_i)
//   Outputs to the datapath  : enables, mux selects, alu_sel_o, illegal_o, state_o
// Modports: master = control unit, slave = datapath side.
// Optional macro MEM_WAIT_EN adds mem_ready_i for multi-cycle memory.
interface mips_multi_ctrl_if;

    logic [my_pkg::OP_WIDTH-1:0]  opcode_i;
    logic [my_pkg::OP_WIDTH-1:0]  funct_i;
    logic                         zeroflag_i;
`ifdef MEM_WAIT_EN
    logic                         mem_ready_i;
`endif
    logic                         pc_en_o;
    logic                         iord_o;
    logic                         mem_write_o;
    logic                         ir_write_o;
    logic                         reg_write_o;
    logic                         reg_dst_o;
    logic                         mem_to_reg_o;
    logic [1:0]                   alusrca_o;
    logic [2:0]                   alusrcb_o;
    logic [1:0]                   pcsrc_o;
    logic [my_pkg::SEL_WIDTH-1:0] alu_sel_o;
    logic                         illegal_o;
    logic [3:0]                   state_o;

    modport master (
`ifdef MEM_WAIT_EN
        input  mem_ready_i,
`endif
        input  opcode_i, funct_i, zeroflag_i,
        output pc_en_o, iord_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
        output mem_to_reg_o, alusrca_o, alusrcb_o, pcsrc_o, alu_sel_o, illegal_o, state_o
    );

    modport slave (
`ifdef MEM_WAIT_EN
        output mem_ready_i,
`endif
        output opcode_i, funct_i, zeroflag_i,
        input  pc_en_o, iord_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
        input  mem_to_reg_o, alusrca_o, alusrcb_o, pcsrc_o, alu_sel_o, illegal_o, state_o
    );

endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation decoder.
//   opcode_i    : instruction opcode field
//   funct_i     : instruction funct field
//   alu_class_i : which field selects the operation (plain add, R, I, branch)
//   alu_sel_o   : ALU operation code
//   valid_o     : the fields name an operation this core implements
module mips_alu_decoder
    import my_pkg::*;
(
    input  logic [OP_WIDTH-1:0] opcode_i,
    input  logic [OP_WIDTH-1:0] funct_i,
    input  alu_class_t          alu_class_i,
    output alu_op_t             alu_sel_o,
    output logic                valid_o
);

    always_comb begin
        alu_sel_o = AluAdd;
        valid_o   = 1'b0;
        case (alu_class_i)
            ClsAdd: valid_o = 1'b1;
            ClsBranch: begin
                alu_sel_o = AluSub;
                valid_o   = (opcode_i == OpBeq) || (opcode_i == OpBne);
            end
            ClsI: begin
                case (opcode_i)
                    OpAddi:  begin alu_sel_o = AluAdd;  valid_o = 1'b1; end
                    OpAndi:  begin alu_sel_o = AluAnnd; valid_o = 1'b1; end
                    OpOri:   begin alu_sel_o = AluOor;  valid_o = 1'b1; end
                    default: ;
                endcase
            end
            ClsR: begin
                case (funct_i)
                    FnAdd:   begin alu_sel_o = AluAdd;  valid_o = 1'b1; end
                    FnSub:   begin alu_sel_o = AluSub;  valid_o = 1'b1; end
                    FnAnd:   begin alu_sel_o = AluAnnd; valid_o = 1'b1; end
                    FnOr:    begin alu_sel_o = AluOor;  valid_o = 1'b1; end
                    FnNor:   begin alu_sel_o = AluNoor; valid_o = 1'b1; end
                    FnSlt:   begin alu_sel_o = AluSlt;  valid_o = 1'b1; end
                    FnSll:   begin alu_sel_o = AluSll;  valid_o = 1'b1; end
                    FnSrl:   begin alu_sel_o = AluSrl;  valid_o = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Main control FSM of the multicycle MIPS core (Moore, one state per step).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; while low all enables and illegal_o are 0
//   bus   : mips_multi_ctrl_if.master -- decode inputs in, datapath controls out
// Optional macro MEM_WAIT_EN: FETCH/MEMRD/MEMWR hold until bus.mem_ready_i is 1.
module mips_multi_ctrl
    import my_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multi_ctrl_if.master      bus
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;

    alu_class_t  w_class;
    alu_op_t     w_dec_sel;
    logic        w_dec_valid;
    logic        w_mem_ready;

    logic        w_pc_en;
    logic        w_iord;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_reg_dst;
    logic        w_mem_to_reg;
    logic [1:0]  w_alusrca;
    logic [2:0]  w_alusrcb;
    logic [1:0]  w_pcsrc;
    alu_op_t     w_alu_sel;
    logic        w_illegal;
    logic        w_is_shift;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready_i;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_is_shift = (bus.funct_i == FnSll) || (bus.funct_i == FnSrl);

    // Kept apart from the main decode so the decoder feedback is not a comb loop.
    always_comb begin
        w_class = ClsAdd;
        case (r_state)
            StExecR:  w_class = ClsR;
            StExecI:  w_class = ClsI;
            StBranch: w_class = ClsBranch;
            default:  w_class = ClsAdd;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .opcode_i    (bus.opcode_i),
        .funct_i     (bus.funct_i),
        .alu_class_i (w_class),
        .alu_sel_o   (w_dec_sel),
        .valid_o     (w_dec_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StFetch;
        w_pc_en      = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alusrca    = SrcAPc;
        w_alusrcb    = SrcBRt;
        w_pcsrc      = PcSrcAlu;
        w_alu_sel    = AluAdd;
        w_illegal    = 1'b0;
        case (r_state)
            StFetch: begin
                // PC+4 goes straight from the ALU into the PC
                w_ir_write   = w_mem_ready;
                w_pc_en      = w_mem_ready;
                w_alusrcb    = SrcBFour;
                w_state_next = w_mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Branch target is computed speculatively into ALUOut
                w_alusrcb = SrcBSImmSh;
                case (bus.opcode_i)
                    OpRtype:             w_state_next = StExecR;
                    OpLw, OpSw:          w_state_next = StMemAdr;
                    OpBeq, OpBne:        w_state_next = StBranch;
                    OpAddi, OpAndi, OpOri: w_state_next = StExecI;
                    OpJ:                 w_state_next = StJump;
                    default: begin
                        w_state_next = StFetch;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            StExecR: begin
                w_alusrca = w_is_shift ? SrcARt : SrcARs;
                w_alusrcb = w_is_shift ? SrcBShamt : SrcBRt;
                if (w_dec_valid) begin
                    w_alu_sel    = w_dec_sel;
                    w_state_next = StAluWbR;
                end else begin
                    w_illegal    = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StAluWbR: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_state_next = StFetch;
            end
            StExecI: begin
                w_alusrca = SrcARs;
                w_alusrcb = (bus.opcode_i == OpAddi) ? SrcBSImm : SrcBZImm;
                if (w_dec_valid) begin
                    w_alu_sel    = w_dec_sel;
                    w_state_next = StAluWbI;
                end else begin
                    w_illegal    = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StAluWbI: begin
                w_reg_write  = 1'b1;
                w_state_next = StFetch;
            end
            StMemAdr: begin
                w_alusrca    = SrcARs;
                w_alusrcb    = SrcBSImm;
                w_state_next = (bus.opcode_i == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                w_iord       = 1'b1;
                w_state_next = w_mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                w_iord       = 1'b1;
                w_mem_write  = 1'b1;
                w_state_next = w_mem_ready ? StFetch : StMemWr;
            end
            StBranch: begin
                w_alusrca    = SrcARs;
                w_alusrcb    = SrcBRt;
                w_alu_sel    = w_dec_sel;
                w_pcsrc      = PcSrcAluOut;
                // Only Mealy-style output: taken/not-taken from the live zero flag
                w_pc_en      = (bus.opcode_i == OpBne) ? ~bus.zeroflag_i : bus.zeroflag_i;
                w_state_next = StFetch;
            end
            StJump: begin
                w_pcsrc      = PcSrcJump;
                w_pc_en      = 1'b1;
                w_state_next = StFetch;
            end
            default: w_state_next = StFetch;
        endcase
    end

    // Reset masks every side-effecting strobe in the same cycle it is low.
    assign bus.pc_en_o      = w_pc_en & rst_n;
    assign bus.iord_o       = w_iord;
    assign bus.mem_write_o  = w_mem_write & rst_n;
    assign bus.ir_write_o   = w_ir_write & rst_n;
    assign bus.reg_write_o  = w_reg_write & rst_n;
    assign bus.reg_dst_o    = w_reg_dst;
    assign bus.mem_to_reg_o = w_mem_to_reg;
    assign bus.alusrca_o    = w_alusrca;
    assign bus.alusrcb_o    = w_alusrcb;
    assign bus.pcsrc_o      = w_pcsrc;
    assign bus.alu_sel_o    = w_alu_sel;
    assign bus.illegal_o    = w_illegal & rst_n;
    assign bus.state_o      = r_state;

endmodule
